// File: rtl/pipe_arith_vr_if.sv
// Producer/consumer bus of pipe_arith_vr: operand/tag input handshake and result/tag output handshake.
// When PIPE_SAT_EN is defined the bus also carries the sticky sat_flag.
interface pipe_arith_vr_if #(
  parameter int W     = 10,
  parameter int TAG_W = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     A;
  logic signed [W-1:0]     B;
  logic signed [W-1:0]     C;
  logic signed [W-1:0]     D;
  logic        [TAG_W-1:0] in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     F;
  logic        [TAG_W-1:0] out_tag;
`ifdef PIPE_SAT_EN
  logic                    sat_flag;
`endif

  modport master (
`ifdef PIPE_SAT_EN
    input  sat_flag,
`endif
    output in_valid, A, B, C, D, in_tag, out_ready,
    input  in_ready, out_valid, F, out_tag
  );

  modport slave (
`ifdef PIPE_SAT_EN
    output sat_flag,
`endif
    input  in_valid, A, B, C, D, in_tag, out_ready,
    output in_ready, out_valid, F, out_tag
  );
endinterface

// File: rtl/pipe_arith_vr.sv
// pipe_arith_vr: 3-stage valid/ready pipeline computing F = ((A+B)+(C-D))*D with tag pass-through.
// Optional feature macro PIPE_SAT_EN: clamp F to the signed W-bit range and add a sticky sat_flag.
module pipe_arith_vr #(
  parameter int W     = 10,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  pipe_arith_vr_if.slave bus
);

  localparam int PW = 2 * W + 2;

  logic w_r1, w_r2, w_r3;
  logic r_v1, r_v2, r_v3;

  logic [W:0]       r_l12, r_l23;
  logic [W-1:0]     r_d1;
  logic [TAG_W-1:0] r_t1;
  logic [W+1:0]     r_l34;
  logic [W-1:0]     r_d2;
  logic [TAG_W-1:0] r_t2;
  logic [W-1:0]     r_f;
  logic [TAG_W-1:0] r_t3;

  logic [W:0]           w_l12, w_l23;
  logic [W+1:0]         w_l34;
  logic signed [PW-1:0] w_p;
  logic [W-1:0]         w_f;

`ifdef PIPE_SAT_EN
  logic         w_clamp;
  logic [W+2:0] w_hi;
  logic         w_fits;
  logic         r_clamp3;
  logic         r_sat;
`else
  logic         w_unused;
`endif

  // Backpressure ready chain, collapsing bubbles from the output back to the input.
  always_comb begin
    w_r3 = !r_v3 || bus.out_ready;
    w_r2 = !r_v2 || w_r3;
    w_r1 = !r_v1 || w_r2;
  end

  // Stage arithmetic with explicit sign extension at each widening step.
  always_comb begin
    w_l12 = {bus.A[W-1], bus.A} + {bus.B[W-1], bus.B};
    w_l23 = {bus.C[W-1], bus.C} - {bus.D[W-1], bus.D};
    w_l34 = {r_l12[W], r_l12} + {r_l23[W], r_l23};
    w_p   = $signed({{W{r_l34[W+1]}}, r_l34}) * $signed({{(W + 2){r_d2[W-1]}}, r_d2});
  end

`ifdef PIPE_SAT_EN
  // Result fits in W bits only when all bits from W-1 upward agree with the sign.
  always_comb begin
    w_hi    = w_p[PW-1:W-1];
    w_fits  = (&w_hi) || !(|w_hi);
    w_f     = w_p[W-1:0];
    w_clamp = 1'b0;
    if (!w_fits) begin
      w_clamp = 1'b1;
      w_f     = w_p[PW-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
    end else begin
      w_f     = w_p[W-1:0];
    end
  end
`else
  // Wrap-around: only the low W product bits reach F.
  always_comb begin
    w_f      = w_p[W-1:0];
    w_unused = ^w_p[PW-1:W];
  end
`endif

  // Stage 1: operand sums and D/tag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_l12 <= '0;
      r_l23 <= '0;
      r_d1  <= '0;
      r_t1  <= '0;
    end else if (flush) begin
      r_v1  <= 1'b0;
    end else if (w_r1) begin
      r_v1  <= bus.in_valid;
      if (bus.in_valid) begin
        r_l12 <= w_l12;
        r_l23 <= w_l23;
        r_d1  <= bus.D;
        r_t1  <= bus.in_tag;
      end
    end
  end

  // Stage 2: combine partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_l34 <= '0;
      r_d2  <= '0;
      r_t2  <= '0;
    end else if (flush) begin
      r_v2  <= 1'b0;
    end else if (w_r2) begin
      r_v2  <= r_v1;
      if (r_v1) begin
        r_l34 <= w_l34;
        r_d2  <= r_d1;
        r_t2  <= r_t1;
      end
    end
  end

  // Stage 3: product, registered straight into the F/out_tag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3     <= 1'b0;
      r_f      <= '0;
      r_t3     <= '0;
`ifdef PIPE_SAT_EN
      r_clamp3 <= 1'b0;
`endif
    end else if (flush) begin
      r_v3     <= 1'b0;
    end else if (w_r3) begin
      r_v3     <= r_v2;
      if (r_v2) begin
        r_f      <= w_f;
        r_t3     <= r_t2;
`ifdef PIPE_SAT_EN
        r_clamp3 <= w_clamp;
`endif
      end
    end
  end

`ifdef PIPE_SAT_EN
  // Sticky flag: set when a clamped result is actually handed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (flush) begin
      r_sat <= 1'b0;
    end else if (r_v3 && bus.out_ready && r_clamp3) begin
      r_sat <= 1'b1;
    end
  end

  assign bus.sat_flag = r_sat;
`endif

  assign bus.in_ready  = w_r1;
  assign bus.out_valid = r_v3;
  assign bus.F         = r_f;
  assign bus.out_tag   = r_t3;

endmodule
